// File: rtl/mmio_regbank.sv
// mmio_regbank: memory-mapped register bank between the core load/store path
// and peripherals. NUM_RO read-only status words (io_r) and NUM_RW read/write
// control words (io_w), one request per cycle over a valid/ready channel with
// a single-entry backpressured response register. Misaligned, malformed,
// out-of-range and write-to-RO accesses answer with rsp_err and change nothing.
//
// Access size encoding on req_dw: 2'b00 byte, 2'b01 halfword, 2'b10 word,
// 2'b11 is rejected as a malformed access.
module mmio_regbank #(
   parameter int          ADDR_W    = 17,
   parameter int          BASE      = 0,
   parameter int          NUM_RO    = 8,
   parameter int          NUM_RW    = 8,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic                  req_we,
   input  logic [1:0]            req_dw,
   input  logic                  req_sext,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   input  logic [NUM_RO*32-1:0]  io_r,
   output logic [NUM_RW*32-1:0]  io_w,
   output logic [NUM_RW-1:0]     io_w_stb
);

   localparam logic [1:0]        DW_B   = 2'b00;
   localparam logic [1:0]        DW_H   = 2'b01;
   localparam logic [1:0]        DW_W   = 2'b10;
   localparam int                IDX_W  = ADDR_W - 2;
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
   localparam logic [ADDR_W:0]   RO_END = (ADDR_W+1)'(4 * NUM_RO);
   localparam logic [ADDR_W:0]   RW_END = (ADDR_W+1)'(4 * (NUM_RO + NUM_RW));

   // Selects the addressed lane(s) of a word and extends to 32 bits.
   function automatic logic [31:0] fmt_read(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [1:0]  dw,
                                            input logic        sext);
      logic        [31:0] sh;
      logic signed [7:0]  b8;
      logic signed [15:0] h16;
      sh  = word >> {lane, 3'b000};
      b8  = sh[7:0];
      h16 = sh[15:0];
      case (dw)
         DW_B:    fmt_read = sext ? 32'(b8)  : {24'h0, sh[7:0]};
         DW_H:    fmt_read = sext ? 32'(h16) : {16'h0, sh[15:0]};
         default: fmt_read = word;
      endcase
   endfunction

   // Merges write data into the addressed byte lanes, keeping the rest.
   function automatic logic [31:0] merge_write(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  dw);
      logic [3:0]  be;
      logic [31:0] sh;
      logic [31:0] res;
      case (dw)
         DW_B:    be = 4'b0001 << lane;
         DW_H:    be = 4'b0011 << lane;
         default: be = 4'b1111;
      endcase
      sh = wdata << {lane, 3'b000};
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? sh[8*i +: 8] : old[8*i +: 8];
      end
      merge_write = res;
   endfunction

   logic [ADDR_W-1:0]     off;
   logic [IDX_W-1:0]      word_idx;
   logic [1:0]            lane;
   logic                  in_ro;
   logic                  in_rw;
   logic                  bad_dw;
   logic                  misalign;
   logic                  err_c;
   logic [31:0]           rd_word;
   logic [31:0]           rdata_c;
   logic [NUM_RW-1:0]     rw_hit;
   logic                  accept;
   logic                  wr_ok;

   logic                  vld_p1;
   logic [31:0]           rdata_p1;
   logic                  err_p1;
   logic [NUM_RW-1:0]     stb_p1;
   logic [NUM_RW*32-1:0]  io_w_p1;

   assign req_ready = !vld_p1 || rsp_ready;
   assign accept    = req_valid && req_ready;
   assign wr_ok     = accept && req_we && !err_c;

   assign rsp_valid = vld_p1;
   assign rsp_rdata = rdata_p1;
   assign rsp_err   = err_p1;
   assign io_w_stb  = stb_p1;
   assign io_w      = io_w_p1;

   // Address decode, error classification and read-data formatting.
   always_comb begin
      off      = req_addr - BASE_A;
      word_idx = off[ADDR_W-1:2];
      lane     = off[1:0];
      in_ro    = {1'b0, off} < RO_END;
      in_rw    = !in_ro && ({1'b0, off} < RW_END);
      rd_word  = '0;
      rw_hit   = '0;
      for (int k = 0; k < NUM_RO; k++) begin
         if (in_ro && word_idx == IDX_W'(k)) begin
            rd_word = io_r[k*32 +: 32];
         end
      end
      for (int k = 0; k < NUM_RW; k++) begin
         if (in_rw && word_idx == IDX_W'(NUM_RO + k)) begin
            rw_hit[k] = 1'b1;
            rd_word   = io_w_p1[k*32 +: 32];
         end
      end
      bad_dw   = (req_dw != DW_B) && (req_dw != DW_H) && (req_dw != DW_W);
      misalign = ((req_dw == DW_H) && off[0]) ||
                 ((req_dw == DW_W) && (off[1:0] != 2'b00));
      err_c    = bad_dw || misalign || !(in_ro || in_rw) || (req_we && in_ro);
      rdata_c  = (err_c || req_we) ? 32'h0
                                   : fmt_read(rd_word, lane, req_dw, req_sext);
   end

   // Response register: loads on accept, holds until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         rdata_p1 <= 32'h0;
         err_p1   <= 1'b0;
      end else if (accept) begin
         vld_p1   <= 1'b1;
         rdata_p1 <= rdata_c;
         err_p1   <= err_c;
      end else if (rsp_ready) begin
         vld_p1   <= 1'b0;
      end
   end

   // Write strobe: one-cycle pulse for the control word just written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb_p1 <= '0;
      end else begin
         stb_p1 <= wr_ok ? rw_hit : '0;
      end
   end

   // Control word storage: byte-lane merge of accepted, error-free writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io_w_p1 <= {NUM_RW{RESET_VAL}};
      end else begin
         for (int k = 0; k < NUM_RW; k++) begin
            if (wr_ok && rw_hit[k]) begin
               io_w_p1[k*32 +: 32] <= merge_write(io_w_p1[k*32 +: 32],
                                                  req_wdata, lane, req_dw);
            end
         end
      end
   end

endmodule

// File: tb/tb_mmio_regbank.sv
// tb_mmio_regbank: directed table-driven bench for mmio_regbank plus
// hand-written sequences for backpressure, streaming and mid-response reset.
module tb_mmio_regbank;

   localparam int          ADDR_W    = 17;
   localparam int          BASE      = 32'h1000;
   localparam int          NUM_RO    = 8;
   localparam int          NUM_RW    = 8;
   localparam logic [31:0] RESET_VAL = 32'h0;

   localparam logic [1:0] DB  = 2'b00;
   localparam logic [1:0] DH  = 2'b01;
   localparam logic [1:0] DW  = 2'b10;
   localparam logic [1:0] BAD = 2'b11;

   logic                  clk;
   logic                  rst_n;
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     req_addr;
   logic                  req_we;
   logic [1:0]            req_dw;
   logic                  req_sext;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;
   logic [NUM_RO*32-1:0]  io_r;
   logic [NUM_RW*32-1:0]  io_w;
   logic [NUM_RW-1:0]     io_w_stb;

   int checks;
   int failures;

   mmio_regbank #(
      .ADDR_W    (ADDR_W),
      .BASE      (BASE),
      .NUM_RO    (NUM_RO),
      .NUM_RW    (NUM_RW),
      .RESET_VAL (RESET_VAL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_we    (req_we),
      .req_dw    (req_dw),
      .req_sext  (req_sext),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .io_r      (io_r),
      .io_w      (io_w),
      .io_w_stb  (io_w_stb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] off;
      logic              we;
      logic [1:0]        dw;
      logic              sext;
      logic [31:0]       wdata;
      logic [31:0]       exp_rdata;
      logic              exp_err;
      logic [7:0]        exp_stb;
      int                wk;
      logic [31:0]       exp_w;
   } vec_t;

   localparam int NV = 22;
   vec_t vt[NV];

   function automatic vec_t mk(input int o, input logic we, input logic [1:0] dw,
                               input logic sext, input logic [31:0] wd,
                               input logic [31:0] er, input logic ee,
                               input logic [7:0] es, input int wk,
                               input logic [31:0] ew);
      vec_t v;
      v.off = ADDR_W'(o); v.we = we; v.dw = dw; v.sext = sext; v.wdata = wd;
      v.exp_rdata = er; v.exp_err = ee; v.exp_stb = es; v.wk = wk; v.exp_w = ew;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input int o, input logic we, input logic [1:0] dw,
                        input logic sext, input logic [31:0] wd);
      req_addr  = ADDR_W'(BASE) + ADDR_W'(o);
      req_we    = we;
      req_dw    = dw;
      req_sext  = sext;
      req_wdata = wd;
      req_valid = 1'b1;
   endtask

   task automatic chk_io_w_reset(input string tag);
      for (int k = 0; k < NUM_RW; k++) begin
         chk($sformatf("%s_io_w%0d", tag, k), io_w[k*32 +: 32], RESET_VAL);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_we    = 1'b0;
      req_dw    = DW;
      req_sext  = 1'b0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      io_r      = '0;
      io_r[0*32 +: 32] = 32'h8000_80F0;
      io_r[7*32 +: 32] = 32'h1234_5678;

      //        off     we    dw   sx  wdata         rdata         err   stb    wk  io_w[wk]
      vt[0]  = mk(0,    1'b0, DB,  1, 32'h0,        32'hFFFF_FFF0, 1'b0, 8'h00, 0, 32'h0);
      vt[1]  = mk(2,    1'b0, DH,  0, 32'h0,        32'h0000_8000, 1'b0, 8'h00, 0, 32'h0);
      vt[2]  = mk(0,    1'b0, DW,  0, 32'h0,        32'h8000_80F0, 1'b0, 8'h00, 0, 32'h0);
      vt[3]  = mk(0,    1'b0, DH,  1, 32'h0,        32'hFFFF_80F0, 1'b0, 8'h00, 0, 32'h0);
      vt[4]  = mk(1,    1'b0, DB,  0, 32'h0,        32'h0000_0080, 1'b0, 8'h00, 0, 32'h0);
      vt[5]  = mk(3,    1'b0, DB,  1, 32'h0,        32'hFFFF_FF80, 1'b0, 8'h00, 0, 32'h0);
      vt[6]  = mk(28,   1'b0, DW,  0, 32'h0,        32'h1234_5678, 1'b0, 8'h00, 0, 32'h0);
      vt[7]  = mk(29,   1'b0, DB,  1, 32'h0,        32'h0000_0056, 1'b0, 8'h00, 0, 32'h0);
      vt[8]  = mk(38,   1'b1, DB,  0, 32'h0000_00AB, 32'h0,        1'b0, 8'h02, 1, 32'h00AB_0000);
      vt[9]  = mk(36,   1'b0, DW,  0, 32'h0,        32'h00AB_0000, 1'b0, 8'h00, 1, 32'h00AB_0000);
      vt[10] = mk(32,   1'b1, DH,  0, 32'h1234_BEEF, 32'h0,        1'b0, 8'h01, 0, 32'h0000_BEEF);
      vt[11] = mk(44,   1'b1, DW,  0, 32'hCAFE_F00D, 32'h0,        1'b0, 8'h08, 3, 32'hCAFE_F00D);
      vt[12] = mk(46,   1'b0, DH,  1, 32'h0,        32'hFFFF_CAFE, 1'b0, 8'h00, 3, 32'hCAFE_F00D);
      vt[13] = mk(45,   1'b0, DB,  0, 32'h0,        32'h0000_00F0, 1'b0, 8'h00, 3, 32'hCAFE_F00D);
      vt[14] = mk(2,    1'b0, DW,  0, 32'h0,        32'h0,         1'b1, 8'h00, 1, 32'h00AB_0000);
      vt[15] = mk(1,    1'b0, DH,  0, 32'h0,        32'h0,         1'b1, 8'h00, 1, 32'h00AB_0000);
      vt[16] = mk(0,    1'b1, DW,  0, 32'hFFFF_FFFF, 32'h0,        1'b1, 8'h00, 1, 32'h00AB_0000);
      vt[17] = mk(64,   1'b0, DW,  0, 32'h0,        32'h0,         1'b1, 8'h00, 1, 32'h00AB_0000);
      vt[18] = mk(0,    1'b0, BAD, 0, 32'h0,        32'h0,         1'b1, 8'h00, 1, 32'h00AB_0000);
      vt[19] = mk(34,   1'b1, DW,  0, 32'hFFFF_FFFF, 32'h0,        1'b1, 8'h00, 0, 32'h0000_BEEF);
      vt[20] = mk(64,   1'b1, DB,  0, 32'hFFFF_FFFF, 32'h0,        1'b1, 8'h00, 1, 32'h00AB_0000);
      vt[21] = mk(39,   1'b1, DB,  0, 32'hFFFF_FF12, 32'h0,        1'b0, 8'h02, 1, 32'h12AB_0000);

      // Reset state
      #12;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_stb", 32'(io_w_stb), 32'h0);
      chk_io_w_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_req_ready", 32'(req_ready), 32'h1);

      // Table of single transactions
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(int'(vt[i].off), vt[i].we, vt[i].dw, vt[i].sext, vt[i].wdata);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
         chk($sformatf("v%0d_rdata", i), rsp_rdata, vt[i].exp_rdata);
         chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vt[i].exp_err));
         chk($sformatf("v%0d_stb", i), 32'(io_w_stb), 32'(vt[i].exp_stb));
         chk($sformatf("v%0d_io_w%0d", i, vt[i].wk), io_w[vt[i].wk*32 +: 32], vt[i].exp_w);
         req_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_rsp_done", i), 32'(rsp_valid), 32'h0);
         chk($sformatf("v%0d_stb_off", i), 32'(io_w_stb), 32'h0);
      end

      // Backpressure: response held, second request waits
      @(negedge clk);
      rsp_ready = 1'b0;
      drive(0, 1'b0, DW, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      io_r[0*32 +: 32] = 32'h1111_1111;
      drive(28, 1'b0, DW, 1'b0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'h0);
         chk($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'h1);
         chk($sformatf("bp%0d_rdata", c), rsp_rdata, 32'h8000_80F0);
         chk($sformatf("bp%0d_err", c), 32'(rsp_err), 32'h0);
         @(posedge clk);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_req_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      chk("bp_next_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_next_rdata", rsp_rdata, 32'h1234_5678);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_drained", 32'(rsp_valid), 32'h0);
      io_r[0*32 +: 32] = 32'h8000_80F0;

      // Streaming: 8 back-to-back word writes
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            chk($sformatf("st%0d_rsp_valid", i-1), 32'(rsp_valid), 32'h1);
            chk($sformatf("st%0d_err", i-1), 32'(rsp_err), 32'h0);
            chk($sformatf("st%0d_stb", i-1), 32'(io_w_stb), 32'(8'h01 << (i-1)));
         end
         if (i < 8) begin
            drive(32 + 4*i, 1'b1, DW, 1'b0, 32'h100 + 32'(i));
            chk($sformatf("st%0d_req_ready", i), 32'(req_ready), 32'h1);
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      chk("st_end_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("st_end_stb", 32'(io_w_stb), 32'h0);
      for (int k = 0; k < NUM_RW; k++) begin
         chk($sformatf("st_io_w%0d", k), io_w[k*32 +: 32], 32'h100 + 32'(k));
      end

      // Reset while a response is pending
      rsp_ready = 1'b0;
      drive(36, 1'b0, DW, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("mr_pending", 32'(rsp_valid), 32'h1);
      chk("mr_pending_rdata", rsp_rdata, 32'h0000_0101);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mr_rdata", rsp_rdata, 32'h0);
      chk("mr_stb", 32'(io_w_stb), 32'h0);
      chk_io_w_reset("mr");
      @(negedge clk);
      rst_n = 1'b1;
      chk("mr_req_ready", 32'(req_ready), 32'h1);
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("mr_no_delivery", 32'(rsp_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
